// File: rtl/shift_sequencer.sv
// Iterative shifter for the ARC ALU. It moves at most MAX_STEP bits per cycle and returns the result over a valid/ready handshake.
// Define SHIFT_SRA_EN to add func 11 (arithmetic right shift); without it, func 11 is reported as unsupported.
module shift_sequencer #(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_func,
  input  logic [WIDTH-1:0] req_data,
  input  logic [4:0]       req_amt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_unsup,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [4:0] STEP_MAX = 5'(MAX_STEP);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_right;
  logic [4:0]       r_rem;
  logic             r_unsup;
  logic             r_req_ready;
  logic             r_res_valid;
  logic             r_busy;

  logic             w_right;
  logic [4:0]       w_amt;
  logic             w_unsup;
  logic [4:0]       w_step;
  logic [4:0]       w_rem_next;
  logic [WIDTH-1:0] w_right_shift;
  logic [WIDTH-1:0] w_shifted;

`ifdef SHIFT_SRA_EN
  logic r_arith;
  logic w_arith;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_right = 1'b0;
    w_amt   = 5'd0;
    w_unsup = 1'b0;
`ifdef SHIFT_SRA_EN
    w_arith = 1'b0;
`endif
    case (req_func)
      4'd4:  begin w_right = 1'b1; w_amt = req_amt; end
      4'd9:  w_amt = 5'd2;
      4'd10: w_amt = 5'd10;
`ifdef SHIFT_SRA_EN
      4'd11: begin w_right = 1'b1; w_amt = req_amt; w_arith = 1'b1; end
`endif
      default: w_unsup = 1'b1;
    endcase
  end

  assign w_step     = (r_rem > STEP_MAX) ? STEP_MAX : r_rem;
  assign w_rem_next = r_rem - w_step;

  // Replicating the MSB on every step is the same as one arithmetic shift of the latched word.
`ifdef SHIFT_SRA_EN
  assign w_right_shift = r_arith ? WIDTH'($signed(r_data) >>> w_step) : (r_data >> w_step);
`else
  assign w_right_shift = r_data >> w_step;
`endif

  assign w_shifted = r_right ? w_right_shift : (r_data << w_step);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_right     <= 1'b0;
      r_rem       <= 5'd0;
      r_unsup     <= 1'b0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SHIFT_SRA_EN
      r_arith     <= 1'b0;
`endif
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_rem       <= 5'd0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_data      <= req_data;
            r_right     <= w_right;
            r_rem       <= w_amt;
            r_unsup     <= w_unsup;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef SHIFT_SRA_EN
            r_arith     <= w_arith;
`endif
            if (w_amt == 5'd0) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == 5'd0) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_data;
  assign res_unsup = r_unsup;
  assign busy      = r_busy;

endmodule
